pipe_reg_chain: RTL and testbench
=================================

# pipe_reg_chain

Parametrised elastic pipeline-register chain, the successor to the fixed-width, always-advancing stage register between CPU pipeline stages. Carries a WIDTH-bit payload through DEPTH registered stages with per-stage valid bits, valid/ready back-pressure, bubble collapsing, global stall and per-stage flush. Sits between any two datapath stages (IF/ID, ID/EX, EX/MEM, MEM/WB) or in front of multi-cycle units, and reports its occupancy.

## Interface
- WIDTH, 32, payload width in bits (1..256)
- DEPTH, 4, number of register stages (1..8)
- RESET_VAL, 0, payload value loaded into every stage on reset
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream beat present
- in_ready  out  1  chain accepts beat this cycle
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  stage DEPTH-1 holds a beat
- out_ready  in  1  downstream accepts beat
- out_data  out  WIDTH  payload of stage DEPTH-1
- stall  in  1  global freeze
- flush  in  DEPTH  per-stage kill mask, bit i = stage i
- occupancy  out  $clog2(DEPTH+2)  number of valid entries held (stages plus skid)

## Operation
- Transfer on an edge where valid and ready are both high; in and out are independent.
- adv[DEPTH-1] = v[DEPTH-1] & out_ready & ~stall; adv[i] = v[i] & (~v[i+1] | adv[i+1]) & ~stall (bubble collapse).
- in_ready = ~rst & ~stall & (~v[0] | adv[0]) (no skid); combinational from out_ready.
- Stage i+1 loads stage i data when adv[i]; stage 0 loads in_data on input handshake.
- Stage data registers load only on a transfer into them; valid bits cleared on advance-out without new load.
- stall: no stage moves, in_ready=0, out_valid=0, contents and occupancy held; flush still applies during stall.
- flush[i]: v[i] cleared at the edge, including any beat entering stage i that edge; a beat leaving stage i that same edge survives unless its destination is flushed. Input beat handshaked with flush[0]=1 is consumed and dropped.
- flush and reset never alter data registers except reset (RESET_VAL).
- occupancy = popcount(v) (+ skid valid); updated registered, equals post-edge state.

## Timing
- Reset: all v=0, all data=RESET_VAL, out_valid=0, occupancy=0, in_ready=0 while rst=1, 1 in first cycle after (unless stall).
- Latency: beat accepted at edge k shows out_valid=1 in the cycle after edge k+DEPTH-1 (DEPTH edges to reach stage DEPTH-1, counting acceptance edge); unchanged with skid when not back-pressured.
- Throughput: one beat per cycle with out_ready held high.
- Full: all DEPTH stages valid and out_ready=0 -> in_ready=0; full and out_ready=1 -> accept and emit in same edge.
- Reset mid-operation: held beats discarded, no output next cycle.

## Configuration
- PIPE_SKID_EN defined: one skid register on input; in_ready = ~rst & ~stall & ~skid_v (registered, no combinational path from out_ready). Input goes straight to stage 0 when it can load; otherwise captured in skid, drained into stage 0 first on next opportunity. Capacity DEPTH+1; flush[0] also clears skid; occupancy includes skid.
- Undefined: no skid, capacity DEPTH, in_ready combinational as above.

## Structure
- Shared package pipe_pkg: DEPTH_MAX=8, WIDTH_MAX=256, occupancy-width function, flush-mask typedef.
- One sub-module pipe_stage (valid bit + WIDTH data register, load/clear/flush inputs), instantiated DEPTH times via generate; skid and handshake logic in top.

## Test plan
- Reset then stream 0x1..0x10 with out_ready=1, DEPTH=4 -> first out_valid after 4 edges, 16 beats in order, one per cycle, occupancy steady at 4.
- out_ready=0, feed 6 beats -> in_ready drops after 4 accepted (5 with PIPE_SKID_EN), occupancy 4 (5); release -> drain in order.
- Bubble collapse: beats A, gap, B with out_ready=0 -> A, B occupy stages 3, 2 with no hole; occupancy 2.
- flush=4'b0100 while stages 1 and 2 valid and advancing -> beat from stage 1 dropped, beat from stage 2 reaches stage 3; occupancy decrements by 1.
- stall=1 for 3 cycles mid-stream -> in_ready=0, out_valid=0, contents unchanged; resume without loss or duplication.
- rst asserted with 3 beats held -> next cycle out_valid=0, occupancy=0, out_data=RESET_VAL.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants, types and helpers for the elastic pipeline-register chain.
package pipe_pkg;

    localparam int unsigned DEPTH_MAX = 8;
    localparam int unsigned WIDTH_MAX = 256;

    typedef logic [DEPTH_MAX-1:0] flush_mask_t;

    // Bits needed to count DEPTH stages plus one optional skid entry.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One chain stage: valid bit plus payload register.
// The payload changes only on load (or reset); the valid bit also reacts to flush and clear.
module pipe_stage #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic             v,
    output logic [WIDTH-1:0] q
);

    // Flush beats everything, including a beat arriving on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
            q <= RESET_VAL;
        end else begin
            if (load) begin
                q <= d;
            end
            if (flush) begin
                v <= 1'b0;
            end else if (load) begin
                v <= 1'b1;
            end else if (clear) begin
                v <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage pipeline register with valid/ready, bubble collapse, stall and flush.
// Optional input skid register enabled by defining PIPE_SKID_EN.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int unsigned       WIDTH     = 32,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          stall,
    input  logic [DEPTH-1:0]              flush,
    output logic [occ_width(DEPTH)-1:0]   occupancy
);

    localparam int unsigned OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] v_nxt;
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic             s0_free;
    logic             load0;
    logic [WIDTH-1:0] d0;
    logic [OCC_W-1:0] occ_nxt;

    // A stage advances when the slot ahead is empty or itself advancing.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = v[DEPTH-1] & out_ready & ~stall;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            adv[i] = v[i] & (~v[i+1] | adv[i+1]) & ~stall;
        end
    end

    assign s0_free = ~stall & (~v[0] | adv[0]);

`ifdef PIPE_SKID_EN
    logic             skid_v;
    logic             skid_v_nxt;
    logic [WIDTH-1:0] skid_d;
    logic             in_fire;
    logic             capture;

    // Registered ready: accept whenever the skid slot is free.
    assign in_ready = ~rst & ~stall & ~skid_v;
    assign in_fire  = in_valid & in_ready;
    assign capture  = in_fire & ~s0_free;
    assign load0    = s0_free & (skid_v | in_fire);
    assign d0       = skid_v ? skid_d : in_data;

    always_comb begin
        skid_v_nxt = skid_v;
        if (flush[0]) begin
            skid_v_nxt = 1'b0;
        end else if (capture) begin
            skid_v_nxt = 1'b1;
        end else if (skid_v && s0_free) begin
            skid_v_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_v <= 1'b0;
            skid_d <= RESET_VAL;
        end else begin
            skid_v <= skid_v_nxt;
            if (capture) begin
                skid_d <= in_data;
            end
        end
    end
`else
    assign in_ready = ~rst & s0_free;
    assign load0    = in_valid & in_ready;
    assign d0       = in_data;
`endif

    always_comb begin
        load = {adv[DEPTH-1:0] << 1} | DEPTH'(load0);
    end

    // Post-edge valid vector, mirrored here to keep occupancy registered.
    always_comb begin
        v_nxt   = v;
        occ_nxt = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (flush[i]) begin
                v_nxt[i] = 1'b0;
            end else if (load[i]) begin
                v_nxt[i] = 1'b1;
            end else if (adv[i]) begin
                v_nxt[i] = 1'b0;
            end
            occ_nxt = occ_nxt + OCC_W'(v_nxt[i]);
        end
`ifdef PIPE_SKID_EN
        occ_nxt = occ_nxt + OCC_W'(skid_v_nxt);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_nxt;
        end
    end

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_stage
        if (g == 0) begin : g_head
            assign stage_d[g] = d0;
        end else begin : g_body
            assign stage_d[g] = stage_q[g-1];
        end

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .load  (load[g]),
            .clear (adv[g]),
            .flush (flush[g]),
            .d     (stage_d[g]),
            .v     (v[g]),
            .q     (stage_q[g])
        );
    end

    assign out_valid = v[DEPTH-1] & ~stall;
    assign out_data  = stage_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed scoreboard bench for pipe_reg_chain (DEPTH=4, WIDTH=32); honours PIPE_SKID_EN.
module tb_pipe_reg_chain;
    import pipe_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned OCC_W = occ_width(DEPTH);
    localparam logic [WIDTH-1:0] RV = 32'hDEAD_BEEF;
`ifdef PIPE_SKID_EN
    localparam int CAP = 5;
`else
    localparam int CAP = 4;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             stall;
    logic [DEPTH-1:0] flush;
    logic [OCC_W-1:0] occupancy;

    int vectors     = 0;
    int miscompares = 0;
    logic [WIDTH-1:0] sb [$];

    always #5 clk = ~clk;

    pipe_reg_chain #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall     (stall),
        .flush     (flush),
        .occupancy (occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, score handshakes, check occupancy after the edge.
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] id, input logic ordy,
                         input logic stl, input logic [DEPTH-1:0] fl, input int drop_idx,
                         output logic acc, output logic emit);
        logic [WIDTH-1:0] exp_d;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        stall     = stl;
        flush     = fl;
        #1;
        acc  = in_valid & in_ready;
        emit = out_valid & out_ready;
        if (drop_idx >= 0 && drop_idx < sb.size()) sb.delete(drop_idx);
        if (emit) begin
            if (sb.size() > 0) exp_d = sb.pop_front();
            else               exp_d = 'x;
            chk("out_data", 64'(out_data), 64'(exp_d));
        end
        if (acc && !fl[0]) sb.push_back(id);
        @(posedge clk);
        #1;
        chk("occupancy", 64'(occupancy), 64'(sb.size()));
        @(negedge clk);
    endtask

    initial begin
        logic a, e;
        int first, n_emit, n_acc, k;
        logic [OCC_W-1:0] occ_before;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stall = 1'b0; flush = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'(RV));
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Stream 0x1..0x10 with out_ready held high.
        first = -1; n_emit = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(i < 16, WIDTH'(i + 1), 1'b1, 1'b0, '0, -1, a, e);
            if (e) begin
                if (first < 0) first = i;
                n_emit++;
            end
            if (i < 16) chk("stream_accept", 64'(a), 64'd1);
        end
        chk("first_out_latency", 64'(first), 64'd4);
        chk("stream_count", 64'(n_emit), 64'd16);

        // Full chain with out_ready=1 accepts and emits on the same edge.
        for (int i = 0; i < 4; i++) cycle(1'b1, WIDTH'(32'h50 + i), 1'b0, 1'b0, '0, -1, a, e);
        cycle(1'b1, 32'h60, 1'b1, 1'b0, '0, -1, a, e);
        chk("full_accept", 64'(a), 64'd1);
        chk("full_emit",   64'(e), 64'd1);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0, '0, -1, a, e);
        chk("full_drained", 64'(out_valid), 64'd0);

        // Back-pressure: offer 6 beats, expect CAP accepted.
        n_acc = 0; k = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, WIDTH'(32'h100 + k), 1'b0, 1'b0, '0, -1, a, e);
            if (a) begin n_acc++; k++; end
        end
        chk("bp_accepted", 64'(n_acc), 64'(CAP));
        #1;
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0, '0, -1, a, e);
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Bubble collapse: A, gap, B under back-pressure.
        cycle(1'b1, 32'hAAAA, 1'b0, 1'b0, '0, -1, a, e);
        cycle(1'b0, '0,       1'b0, 1'b0, '0, -1, a, e);
        cycle(1'b1, 32'hBBBB, 1'b0, 1'b0, '0, -1, a, e);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b0, '0, -1, a, e);
        chk("bubble_occ", 64'(occupancy), 64'd2);
        cycle(1'b0, '0, 1'b1, 1'b0, '0, -1, a, e);
        chk("bubble_a_out", 64'(e), 64'd1);
        cycle(1'b0, '0, 1'b1, 1'b0, '0, -1, a, e);
        chk("bubble_b_no_hole", 64'(e), 64'd1);
        cycle(1'b0, '0, 1'b1, 1'b0, '0, -1, a, e);
        chk("bubble_empty", 64'(occupancy), 64'd0);

        // Flush stage 2 while the chain streams: the beat moving out of stage 1 dies.
        occ_before = '0;
        for (int i = 0; i < 10; i++) begin
            if (i == 6) begin
                occ_before = occupancy;
                chk("flush_pre_full", 64'(occ_before), 64'd4);
                cycle(1'b1, WIDTH'(32'h200 + i), 1'b1, 1'b0, 4'b0100, 2, a, e);
                chk("flush_occ_dec", 64'(occupancy), 64'(occ_before - 1'b1));
            end else begin
                cycle(1'b1, WIDTH'(32'h200 + i), 1'b1, 1'b0, '0, -1, a, e);
            end
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0, '0, -1, a, e);
        chk("flush_drained", 64'(out_valid), 64'd0);

        // Stall three cycles mid-stream.
        k = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, WIDTH'(32'h400 + k), 1'b1, (i >= 5 && i <= 7), '0, -1, a, e);
            if (i >= 5 && i <= 7) begin
                chk("stall_in_ready",  64'(a), 64'd0);
                chk("stall_out_valid", 64'(e), 64'd0);
            end
            if (a) k++;
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0, '0, -1, a, e);
        chk("stall_drained", 64'(out_valid), 64'd0);

        // Reset with three beats held.
        for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(32'h300 + i), 1'b0, 1'b0, '0, -1, a, e);
        in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_in_ready",  64'(in_ready),  64'd0);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_occupancy", 64'(occupancy), 64'd0);
        chk("mid_rst_out_data",  64'(out_data),  64'(RV));
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 32'h3FF, 1'b1, 1'b0, '0, -1, a, e);
        chk("post_mid_rst_accept", 64'(a), 64'd1);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0, '0, -1, a, e);
        chk("final_empty", 64'(occupancy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
